// File: rtl/sterownik_stopera.sv
// ---------------------------------------------------------------------------
// sterownik_stopera -- stopwatch controller with BCD seconds display.
//
// A prescaler divides CLK by DIV to produce count ticks. The seconds count is
// kept as two BCD digits and stops at LIMIT, where the controller parks in
// DONE until cleared or reset.
//
// Parameters
//   DIV     clock cycles per count tick (2..65535)
//   LIMIT   terminal count in seconds (1..59)
//
// Ports
//   CLK      in   clock, all state changes on the rising edge
//   RST      in   asynchronous reset, active low
//   START    in   start / resume request
//   STOP     in   pause request
//   CLR      in   synchronous clear to idle (highest priority)
//   TICK     out  one-cycle pulse per count increment
//   SEC_U    out  units digit of seconds, 0..9
//   SEC_T    out  tens digit of seconds, 0..5
//   RUNNING  out  high only in RUN
//   DONE     out  high only in DONE
// ---------------------------------------------------------------------------
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cleared, count 00, waiting for START
// S_RUN   | prescaler running, count advances every DIV cycles
// S_PAUSE | prescaler and count held, START resumes
// S_DONE  | count reached LIMIT and is frozen, only CLR/RST leave
// ---------------------------------------------------------------------------
module sterownik_stopera #(
    parameter int DIV   = 100,
    parameter int LIMIT = 59
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLR,
    output logic       TICK,
    output logic [3:0] SEC_U,
    output logic [2:0] SEC_T,
    output logic       RUNNING,
    output logic       DONE
);

    localparam int              PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   P_MAX = PW'(DIV - 1);
    localparam logic [3:0]      LIM_U = 4'(LIMIT % 10);
    localparam logic [2:0]      LIM_T = 3'(LIMIT / 10);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   p_q;
    logic [3:0]      sec_u_q;
    logic [2:0]      sec_t_q;
    logic            tick_q;
    logic            running_q;
    logic            done_q;

    // Incremented BCD value, used only on a prescaler wrap.
    logic [3:0]      sec_u_d;
    logic [2:0]      sec_t_d;
    logic            hit_limit;

    always_comb begin
        if (sec_u_q == 4'd9) begin
            sec_u_d = 4'd0;
            sec_t_d = sec_t_q + 3'd1;
        end else begin
            sec_u_d = sec_u_q + 4'd1;
            sec_t_d = sec_t_q;
        end
        hit_limit = (sec_u_d == LIM_U) && (sec_t_d == LIM_T);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            p_q       <= '0;
            sec_u_q   <= 4'd0;
            sec_t_q   <= 3'd0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // TICK is a single-cycle pulse; only a prescaler wrap re-arms it.
            tick_q <= 1'b0;
            if (CLR) begin
                state_q   <= S_IDLE;
                p_q       <= '0;
                sec_u_q   <= 4'd0;
                sec_t_q   <= 3'd0;
                running_q <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // STOP has no meaning here, so START alone decides.
                        if (START) begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (STOP) begin
                            // Pause edge freezes everything, even at P_MAX.
                            state_q   <= S_PAUSE;
                            running_q <= 1'b0;
                        end else if (p_q == P_MAX) begin
                            p_q     <= '0;
                            sec_u_q <= sec_u_d;
                            sec_t_q <= sec_t_d;
                            tick_q  <= 1'b1;
                            if (hit_limit) begin
                                state_q   <= S_DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            p_q <= p_q + PW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (START) begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                        done_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign TICK    = tick_q;
    assign SEC_U   = sec_u_q;
    assign SEC_T   = sec_t_q;
    assign RUNNING = running_q;
    assign DONE    = done_q;

endmodule

// File: doc/sterownik_stopera.md
STEROWNIK_STOPERA -- requirements
Module: sterownik_stopera

Interface
REQ-001 SHALL have parameter DIV, default 100: clock cycles per count tick; legal 2..65535.
REQ-002 SHALL have parameter LIMIT, default 59: terminal count in seconds; legal 1..59.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port START, input, 1 bit: start or resume request, sampled each edge.
REQ-006 SHALL have port STOP, input, 1 bit: pause request, sampled each edge.
REQ-007 SHALL have port CLR, input, 1 bit: synchronous clear to idle, sampled each edge.
REQ-008 SHALL have port TICK, output, 1 bit: one-cycle pulse per count increment.
REQ-009 SHALL have port SEC_U, output, 4 bits: units digit of seconds, 0..9.
REQ-010 SHALL have port SEC_T, output, 3 bits: tens digit of seconds, 0..5.
REQ-011 SHALL have port RUNNING, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port DONE, output, 1 bit: high only in state DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-014 SHALL hold an internal prescaler P of width $clog2(DIV), counting 0..DIV-1.
REQ-015 SHALL apply input priority CLR > STOP > START each edge.
REQ-016 SHALL go, on CLR in any state: IDLE, P=0, SEC_U=0, SEC_T=0, TICK=0.
REQ-017 SHALL go IDLE->RUN on START; P stays 0; no count change on that edge.
REQ-018 SHALL in RUN with no STOP/CLR: increment P if P<DIV-1; else P<=0, increment count, TICK<=1 for the next cycle.
REQ-019 SHALL assert TICK for exactly one cycle per increment and 0 at all other times.
REQ-020 SHALL make the first increment after START land on the DIV-th RUN edge, then every DIV edges.
REQ-021 SHALL increment as BCD: SEC_U 9->0 with carry SEC_T+1; SEC_U<9 -> SEC_U+1, SEC_T held.
REQ-022 SHALL, on an increment whose result equals LIMIT (10*SEC_T+SEC_U), enter DONE on that edge with count frozen at LIMIT; TICK still pulses.
REQ-023 SHALL go RUN->PAUSE on STOP; on that edge no P change, no increment, no TICK, even if P==DIV-1.
REQ-024 SHALL in PAUSE hold P and count; START -> RUN, counting continues from held P.
REQ-025 SHALL ignore STOP in IDLE, PAUSE, DONE; ignore START in RUN and DONE.
REQ-026 SHALL leave DONE only via CLR or reset.
REQ-027 SHALL never let the count exceed LIMIT; no wrap past 59 occurs.

Reset
REQ-028 SHALL on RST=0, immediately and independent of CLK: state IDLE, P=0, SEC_U=0, SEC_T=0, TICK=0, RUNNING=0, DONE=0.
REQ-029 SHALL hold reset values while RST=0 regardless of other inputs; resume on first edge after RST=1.
REQ-030 SHALL allow reset assertion in any state, including mid-RUN between edges.

Verification (DIV=4, LIMIT=12)
REQ-031 SHALL cover: START 1 cycle from IDLE -> RUNNING=1 next cycle; TICK high on every 4th cycle; SEC_U=1 after the 4th RUN edge.
REQ-032 SHALL cover: run 10 ticks -> SEC_T=1, SEC_U=0 after the 10th; no intermediate value above 9.
REQ-033 SHALL cover: run to 12 ticks -> DONE=1, RUNNING=0, SEC_T=1/SEC_U=2 frozen; later START and STOP -> no change; CLR -> IDLE, 00.
REQ-034 SHALL cover: STOP asserted when P=3 -> PAUSE, no TICK, count unchanged; START 5 cycles later -> TICK on the first RUN edge.
REQ-035 SHALL cover: CLR, STOP, START all high during RUN -> IDLE, count 00, RUNNING=0.
REQ-036 SHALL cover: RST=0 pulse mid-RUN at count 07 between edges -> all outputs 0 before the next CLK edge; after release, START needed to run.
